// File: rtl/athos_pkg.sv
// athos_pkg: shared types, constants and helpers for the polynomial
// coefficient unpacker (poly_unpack_stream and its FSM).
package athos_pkg;

  // Field-width select encoding, latched when a polynomial starts.
  typedef enum logic [1:0] {
    DSEL_4  = 2'd0,
    DSEL_5  = 2'd1,
    DSEL_10 = 2'd2,
    DSEL_11 = 2'd3
  } d_sel_e;

  // Control states of the unpacker.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } unpack_state_e;

  // Coefficients per polynomial.
  localparam int unsigned COEF_COUNT = 256;
  // Bit buffer width and the width of its fill counter (0..64).
  localparam int unsigned BUF_W  = 64;
  localparam int unsigned FILL_W = 7;
  // Packed input word width.
  localparam int unsigned WORD_W = 32;
  // Index of the final coefficient of a polynomial.
  localparam logic [7:0] LAST_COEF_IDX = 8'(COEF_COUNT - 1);

  // Field width d for a given select code.
  function automatic logic [3:0] d_from_sel(input d_sel_e sel);
    logic [3:0] d;
    case (sel)
      DSEL_4:  d = 4'd4;
      DSEL_5:  d = 4'd5;
      DSEL_10: d = 4'd10;
      DSEL_11: d = 4'd11;
      default: d = 4'd4;
    endcase
    return d;
  endfunction

  // Words making up one polynomial: 256*d bits / 32 = 8*d.
  function automatic logic [6:0] words_for_d(input logic [3:0] d);
    return {d, 3'b000};
  endfunction

endpackage

// File: rtl/poly_unpack_fsm.sv
// poly_unpack_fsm: control for poly_unpack_stream. Tracks the IDLE/RUN/DONE
// state, the number of packed words accepted and the index of the
// coefficient currently presented downstream.
module poly_unpack_fsm
  import athos_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_word_hs,
  input  logic          i_coef_hs,
  output unpack_state_e o_state,
  output logic [6:0]    o_word_cnt,
  output logic [7:0]    o_coef_idx,
  output logic          o_busy,
  output logic          o_done
);

  unpack_state_e r_state;
  logic [6:0]    r_word_cnt;
  logic [7:0]    r_coef_idx;
  logic          r_busy;
  logic          r_done;

  // State, counters and registered busy/done flags advance together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_word_cnt <= 7'd0;
      r_coef_idx <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state    <= ST_RUN;
            r_word_cnt <= 7'd0;
            r_coef_idx <= 8'd0;
            r_busy     <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          if (i_word_hs) begin
            r_word_cnt <= r_word_cnt + 7'd1;
          end
          if (i_coef_hs) begin
            r_coef_idx <= r_coef_idx + 8'd1;
            // Handshake of the last coefficient closes the polynomial.
            if (r_coef_idx == LAST_COEF_IDX) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_word_cnt <= 7'd0;
          r_coef_idx <= 8'd0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_word_cnt = r_word_cnt;
  assign o_coef_idx = r_coef_idx;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: rtl/poly_unpack_stream.sv
// poly_unpack_stream: unpacks a stream of 32-bit words into 256 d-bit
// coefficients (d = 4/5/10/11), LSB-first, through a 64-bit bit buffer.
// Optional feature: define ATHOS_UNPACK_ERR_EN to build the sticky protocol
// error flag on err_o; otherwise err_o is tied low.
module poly_unpack_stream
  import athos_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  d_sel_i,
  input  logic        word_valid_i,
  input  logic [31:0] word_i,
  output logic        word_ready_o,
  output logic        coef_valid_o,
  output logic [15:0] coef_o,
  input  logic        coef_ready_i,
  output logic [7:0]  coef_idx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  // Datapath registers.
  logic [BUF_W-1:0]  r_buf;
  logic [FILL_W-1:0] r_fill;
  logic [3:0]        r_d;

  // Control from the FSM.
  unpack_state_e     w_state;
  logic [6:0]        w_word_cnt;
  logic [7:0]        w_coef_idx;
  logic              w_busy;
  logic              w_done;

  // Derived control.
  logic              w_run;
  logic              w_start_acc;
  logic              w_words_left;
  logic              w_word_ready;
  logic              w_coef_valid;
  logic              w_word_hs;
  logic              w_coef_hs;
  logic [FILL_W-1:0] w_d_ext;

  // Next-state datapath.
  logic [BUF_W-1:0]  w_buf_shift;
  logic [FILL_W-1:0] w_fill_after;
  logic [BUF_W-1:0]  w_buf_next;
  logic [FILL_W-1:0] w_fill_next;
  logic [15:0]       w_coef_mask;

  poly_unpack_fsm u_fsm (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_start    (start_i),
    .i_word_hs  (w_word_hs),
    .i_coef_hs  (w_coef_hs),
    .o_state    (w_state),
    .o_word_cnt (w_word_cnt),
    .o_coef_idx (w_coef_idx),
    .o_busy     (w_busy),
    .o_done     (w_done)
  );

  assign w_run        = (w_state == ST_RUN);
  assign w_start_acc  = start_i && (w_state == ST_IDLE);
  assign w_d_ext      = {3'b000, r_d};
  assign w_words_left = (w_word_cnt < words_for_d(r_d));

  // Room for a whole word exists only while at most 32 bits are buffered.
  assign w_word_ready = w_run && (r_fill <= 7'd32) && w_words_left;
  assign w_coef_valid = w_run && (r_fill >= w_d_ext);
  assign w_word_hs    = word_valid_i && w_word_ready;
  assign w_coef_hs    = w_coef_valid && coef_ready_i;

  // Next buffer/fill: consume d bits first, then append the word at the
  // resulting fill so a same-cycle word lands directly above the survivors.
  always_comb begin
    w_buf_shift  = r_buf;
    w_fill_after = r_fill;
    w_buf_next   = r_buf;
    w_fill_next  = r_fill;
    if (w_coef_hs) begin
      w_buf_shift  = r_buf >> r_d;
      w_fill_after = r_fill - w_d_ext;
    end else begin
      w_buf_shift  = r_buf;
      w_fill_after = r_fill;
    end
    if (w_word_hs) begin
      w_buf_next  = w_buf_shift | ({{(BUF_W - WORD_W){1'b0}}, word_i} << w_fill_after);
      w_fill_next = w_fill_after + 7'd32;
    end else begin
      w_buf_next  = w_buf_shift;
      w_fill_next = w_fill_after;
    end
  end

  // Bit buffer, fill count and latched field width.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf  <= '0;
      r_fill <= 7'd0;
      r_d    <= 4'd0;
    end else if (w_start_acc) begin
      r_buf  <= '0;
      r_fill <= 7'd0;
      r_d    <= d_from_sel(d_sel_e'(d_sel_i));
    end else if (w_run) begin
      r_buf  <= w_buf_next;
      r_fill <= w_fill_next;
    end
  end

  // Low d bits of the buffer, upper bits forced to zero.
  assign w_coef_mask = (16'd1 << r_d) - 16'd1;

  assign word_ready_o = w_word_ready;
  assign coef_valid_o = w_coef_valid;
  assign coef_o       = r_buf[15:0] & w_coef_mask;
  assign coef_idx_o   = w_coef_idx;
  assign busy_o       = w_busy;
  assign done_o       = w_done;

`ifdef ATHOS_UNPACK_ERR_EN
  logic r_err;
  logic w_err_set;

  // Protocol violations: start outside IDLE, or a word offered once all
  // words of the current polynomial have been taken.
  always_comb begin
    w_err_set = 1'b0;
    if (start_i && (w_state != ST_IDLE)) begin
      w_err_set = 1'b1;
    end else if (word_valid_i && w_run && !w_words_left) begin
      w_err_set = 1'b1;
    end else begin
      w_err_set = 1'b0;
    end
  end

  // Sticky error flag; only reset or an accepted start clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_poly_unpack_stream.sv
// Testbench for poly_unpack_stream: randomized word/ready traffic checked
// every cycle against a count-based reference model of the unpacker.
module tb_poly_unpack_stream;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  d_sel_i = 2'd0;
  logic        word_valid_i = 1'b0;
  logic [31:0] word_i = 32'd0;
  logic        coef_ready_i = 1'b0;
  logic        word_ready_o;
  logic        coef_valid_o;
  logic [15:0] coef_o;
  logic [7:0]  coef_idx_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

`ifdef ATHOS_UNPACK_ERR_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  always #5 clk = ~clk;

  poly_unpack_stream dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .d_sel_i      (d_sel_i),
    .word_valid_i (word_valid_i),
    .word_i       (word_i),
    .word_ready_o (word_ready_o),
    .coef_valid_o (coef_valid_o),
    .coef_o       (coef_o),
    .coef_ready_i (coef_ready_i),
    .coef_idx_o   (coef_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  // Stimulus data shared between driver (writer) and monitor (reader).
  logic [31:0] words [0:87];
  logic [15:0] exp_coef [0:255];
  int          nwords = 0;
  int          test_id = 0;
  int          post_req = 0;
  bit          stall_active = 1'b0;

  // Monitor-owned state.
  int          checks = 0;
  int          failures = 0;
  int          post_done = 0;
  int          words_taken = 0;
  int          coef_seen = 0;
  int          m_d = 0;
  int          cyc = 0;
  int          done_pulses = 0;
  int          fill_m = 0;
  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          saw_drop = 1'b0;
  bit          o_run = 1'b0;
  bit          o_done = 1'b0;
  bit          start_acc = 1'b0;
  logic [15:0] got_coef [0:255];
  int          got_cyc [0:255];

  function automatic int dtab(input logic [1:0] s);
    case (s)
      2'd0:    return 4;
      2'd1:    return 5;
      2'd2:    return 10;
      default: return 11;
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference unpack: coefficient k is stream bits [k*d +: d], LSB-first.
  task automatic build_exp(input int d);
    for (int k = 0; k < 256; k++) begin
      int v;
      v = 0;
      for (int b = 0; b < d; b++) begin
        int pos;
        pos = k * d + b;
        if (words[pos / 32][pos % 32]) v += (1 << b);
      end
      exp_coef[k] = v[15:0];
    end
  endtask

  // End-of-polynomial checks, including literal pins for model and DUT.
  task automatic run_post();
    int lit10 [0:5];
    lit10 = '{32'h3FF, 32'h3FF, 32'h3FF, 32'h003, 32'h000, 32'h000};
    case (test_id)
      1: begin
        for (int i = 0; i < 8; i++) begin
          chk("d4_model_coef", exp_coef[i], i + 1);
          chk("d4_dut_coef", got_coef[i], i + 1);
        end
        chk("d4_consecutive", got_cyc[7] - got_cyc[0], 7);
      end
      2: begin
        for (int i = 0; i < 6; i++) begin
          chk("d10_model_coef", exp_coef[i], lit10[i]);
          chk("d10_dut_coef", got_coef[i], lit10[i]);
        end
      end
      4: chk("stall_word_ready_drop", saw_drop, 1);
      7: chk("err_sticky", err_o, ERR_EXP);
      default: ;
    endcase
    chk("coef_count", coef_seen, 256);
    chk("word_count", words_taken, 8 * m_d);
    chk("done_pulses", done_pulses, 1);
  endtask

  // Monitor: compare DUT against the model on each falling edge, then
  // advance the model by the handshakes that the next rising edge performs.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_i) begin
        chk("reset_outputs", {word_ready_o, coef_valid_o, coef_o, coef_idx_o, busy_o, done_o, err_o}, 0);
        m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
        words_taken = 0; coef_seen = 0; m_d = 0;
      end else begin
        fill_m = words_taken * 32 - coef_seen * m_d;
        chk("word_ready", word_ready_o, m_run && (fill_m <= 32) && (words_taken < 8 * m_d));
        chk("coef_valid", coef_valid_o, m_run && (fill_m >= m_d));
        chk("busy", busy_o, m_run);
        chk("done", done_o, m_done);
        chk("err", err_o, m_err);
        if (m_run && coef_valid_o && coef_seen < 256) begin
          chk("coef_value", coef_o, exp_coef[coef_seen]);
          chk("coef_idx", coef_idx_o, coef_seen % 256);
        end
        if (stall_active && m_run && fill_m > 32 && !word_ready_o) saw_drop = 1'b1;
        if (done_o) done_pulses++;
        o_run = m_run;
        o_done = m_done;
        start_acc = start_i && !o_run && !o_done;
        m_done = 1'b0;
`ifdef ATHOS_UNPACK_ERR_EN
        if (start_acc) m_err = 1'b0;
        else if ((start_i && (o_run || o_done)) || (word_valid_i && o_run && words_taken >= 8 * m_d)) m_err = 1'b1;
`endif
        if (start_acc) begin
          m_run = 1'b1; m_d = dtab(d_sel_i);
          words_taken = 0; coef_seen = 0; done_pulses = 0; saw_drop = 1'b0;
        end else if (o_run) begin
          if (word_valid_i && word_ready_o) words_taken++;
          if (coef_valid_o && coef_ready_i) begin
            got_coef[coef_seen] = coef_o;
            got_cyc[coef_seen] = cyc;
            coef_seen++;
            if (coef_seen == 256) begin
              m_run = 1'b0;
              m_done = 1'b1;
            end
          end
        end
      end
      if (post_req != post_done) begin
        post_done = post_req;
        run_post();
      end
    end
  end

  // One polynomial. rmode: 0 always ready, 1 random, 2 ten-cycle stall at
  // coef 40. vmode: 0 always valid, 1 random. abort_at >= 0 resets mid-run;
  // err_at >= 0 issues a stray start during RUN.
  task automatic run_poly(input int tid, input logic [1:0] dsel, input int rmode,
                          input int vmode, input int abort_at, input int err_at,
                          input bit extra_valid);
    int d, timer, stall_left;
    bit err_done, stalled;
    d = dtab(dsel);
    nwords = 8 * d;
    for (int i = 0; i < nwords; i++) words[i] = $urandom;
    if (tid == 1) words[0] = 32'h87654321;
    if (tid == 2) begin
      words[0] = 32'hFFFFFFFF;
      words[1] = 32'h00000000;
    end
    build_exp(d);
    test_id = tid;
    @(posedge clk); #1;
    start_i = 1'b1; d_sel_i = dsel;
    @(posedge clk); #1;
    start_i = 1'b0; d_sel_i = 2'($urandom_range(0, 3));
    timer = 0; stall_left = 0; stalled = 1'b0; err_done = 1'b0;
    while (coef_seen < 256 && timer < 4000) begin
      if (abort_at >= 0 && coef_seen >= abort_at) break;
      if (words_taken < nwords) begin
        word_valid_i = (vmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        word_i = words[words_taken];
      end else begin
        word_valid_i = extra_valid;
        word_i = $urandom;
      end
      case (rmode)
        0: coef_ready_i = 1'b1;
        1: coef_ready_i = ($urandom_range(0, 3) != 0);
        default: begin
          if (!stalled && coef_seen >= 40) begin
            stalled = 1'b1;
            stall_left = 10;
          end
          if (stall_left > 0) begin
            coef_ready_i = 1'b0; stall_left--; stall_active = 1'b1;
          end else begin
            coef_ready_i = 1'b1; stall_active = 1'b0;
          end
        end
      endcase
      start_i = (err_at >= 0) && !err_done && (coef_seen >= err_at);
      if (start_i) begin
        err_done = 1'b1;
        d_sel_i = 2'd3;
      end
      @(posedge clk); #1;
      timer++;
    end
    word_valid_i = 1'b0; coef_ready_i = 1'b1; start_i = 1'b0; stall_active = 1'b0;
    if (abort_at >= 0) begin
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      @(posedge clk); #1;
    end else begin
      repeat (3) @(posedge clk);
      #1 post_req++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(posedge clk); #1;
    run_poly(1, 2'd0, 0, 0, -1, -1, 1'b0);   // d=4 literal start
    run_poly(2, 2'd2, 0, 0, -1, -1, 1'b0);   // d=10 word-boundary straddle
    run_poly(3, 2'd3, 1, 1, -1, -1, 1'b0);   // d=11 random stalls
    run_poly(4, 2'd1, 2, 0, -1, -1, 1'b0);   // d=5 ten-cycle backpressure
    run_poly(5, 2'd2, 1, 1, 100, -1, 1'b0);  // d=10 reset at coef 100
    run_poly(6, 2'd0, 1, 1, -1, -1, 1'b0);   // fresh d=4 after abort
    run_poly(7, 2'd1, 1, 1, -1, 20, 1'b1);   // stray start + extra words
    run_poly(8, 2'd3, 0, 0, -1, -1, 1'b0);   // accepted start clears err
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
